bp_update_sched: RTL and testbench

//  Scheduler for the branch predictor's retire-side update port. Buffers retired-branch

---
 rtl/bp_update_sched_pkg.sv | 35 +++
 rtl/bp_update_sched_fifo.sv | 56 +++++
 rtl/bp_update_sched.sv | 150 +++++++++++++++
 tb/tb_bp_update_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bp_update_sched_pkg
//  Brief   : Shared types for the branch-predictor retire-update scheduler:
//            the update record carried to BP and the scheduler state encoding.
//  Revision: 1.0  initial release
// ============================================================================
package bp_update_sched_pkg;

    // Outstanding-branch-queue size; the branch index carries one extra bit
    // so that wrap-around generations can be told apart.
    localparam int OBQ_SIZE    = 16;
    localparam int c_obq_idx_w = $clog2(OBQ_SIZE) + 1;

    // One retired-branch update as presented to the predictor structures
    typedef struct packed {
        logic                   cond;
        logic                   direct;
        logic                   taken;
        logic                   correct;
        logic [31:0]            pc;
        logic [31:0]            calc_pc;
        logic [c_obq_idx_w-1:0] index;
    } BP_UPD_T;

    // RUN: normal issue; DRAIN: flush older updates ahead of a held
    // mispredict; RECOVER: hold fetch lookups while rollback settles.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        RECOVER = 2'd2
    } BP_SCHED_STATE_T;

endpackage
`default_nettype wire

// File: rtl/bp_update_sched_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : bp_upd_fifo
//  Brief   : Small FIFO of correctly-predicted retire updates. Pointers are
//            one bit wider than the address so full and empty are distinct.
//  Revision: 1.0  initial release
// ============================================================================
module bp_upd_fifo
    import bp_update_sched_pkg::*;
#(
    parameter int UQ_DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  BP_UPD_T push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output BP_UPD_T head
);

    localparam int c_addr_w = $clog2(UQ_DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;

    BP_UPD_T              r_mem [UQ_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr[c_addr_w-1:0]];

    // Pointer bookkeeping; both wrap naturally modulo twice the depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    // Entry storage; contents are don't-care while the slot is not live
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module  : bp_update_sched
//  Brief   : Retire-side update scheduler for the branch predictor. Queues
//            correct updates, issues one per cycle, orders a mispredict
//            behind all older updates, then stalls fetch lookups for a fixed
//            number of recovery cycles.
//  Revision: 1.0  initial release
// ============================================================================
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int UQ_DEPTH       = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   rt_en_branch,
    input  logic                   rt_cond_branch,
    input  logic                   rt_direct_branch,
    input  logic                   rt_branch_taken,
    input  logic                   rt_prediction_correct,
    input  logic [31:0]            rt_pc,
    input  logic [31:0]            rt_calculated_pc,
    input  logic [c_obq_idx_w-1:0] rt_branch_index,
    output logic                   rt_ready,
    output logic                   bp_rt_en_branch,
    output logic                   bp_rt_cond_branch,
    output logic                   bp_rt_direct_branch,
    output logic                   bp_rt_branch_taken,
    output logic                   bp_rt_prediction_correct,
    output logic [31:0]            bp_rt_pc,
    output logic [31:0]            bp_rt_calculated_pc,
    output logic [c_obq_idx_w-1:0] bp_rt_branch_index,
    output logic                   bp_fetch_stall,
    output logic                   recover_busy
);

    localparam int c_cnt_w = $clog2(RECOVER_CYCLES + 1);

    BP_SCHED_STATE_T      r_state;
    BP_UPD_T              r_misp;
    BP_UPD_T              r_issue;
    logic                 r_issue_en;
    logic                 r_stall;
    logic [c_cnt_w-1:0]   r_cnt;

    BP_UPD_T              w_rt_upd;
    BP_UPD_T              w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;

    assign w_rt_upd = '{cond:    rt_cond_branch,
                        direct:  rt_direct_branch,
                        taken:   rt_branch_taken,
                        correct: rt_prediction_correct,
                        pc:      rt_pc,
                        calc_pc: rt_calculated_pc,
                        index:   rt_branch_index};

    // Readiness uses only the current state; a pop this cycle earns no credit
    assign rt_ready = enable && (r_state == RUN) && !w_full;
    assign w_accept = rt_en_branch && rt_ready;
    assign w_push   = w_accept && rt_prediction_correct;
    assign w_pop    = enable && !w_empty && ((r_state == RUN) || (r_state == DRAIN));

    bp_upd_fifo #(
        .UQ_DEPTH (UQ_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_rt_upd),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Scheduler FSM with registered issue port and fetch-stall output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_misp     <= '0;
            r_issue    <= '0;
            r_issue_en <= 1'b0;
            r_stall    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // Issue port idles at zero unless something is sent this edge
            r_issue_en <= 1'b0;
            r_issue    <= '0;
            if (enable) begin
                case (r_state)
                    RUN: begin
                        if (w_pop) begin
                            r_issue_en <= 1'b1;
                            r_issue    <= w_head;
                        end
                        // Mispredict is parked until every older update has gone
                        if (w_accept && !rt_prediction_correct) begin
                            r_misp  <= w_rt_upd;
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!w_empty) begin
                            r_issue_en <= 1'b1;
                            r_issue    <= w_head;
                        end else begin
                            r_issue_en <= 1'b1;
                            r_issue    <= r_misp;
                            r_stall    <= 1'b1;
                            r_cnt      <= c_cnt_w'(RECOVER_CYCLES);
                            r_state    <= RECOVER;
                        end
                    end
                    RECOVER: begin
                        if (r_cnt == c_cnt_w'(1)) begin
                            r_stall <= 1'b0;
                            r_state <= RUN;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_w'(1);
                        end
                    end
                    default: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

    assign bp_rt_en_branch          = r_issue_en;
    assign bp_rt_cond_branch        = r_issue.cond;
    assign bp_rt_direct_branch      = r_issue.direct;
    assign bp_rt_branch_taken       = r_issue.taken;
    assign bp_rt_prediction_correct = r_issue.correct;
    assign bp_rt_pc                 = r_issue.pc;
    assign bp_rt_calculated_pc      = r_issue.calc_pc;
    assign bp_rt_branch_index       = r_issue.index;
    assign bp_fetch_stall           = r_stall;
    assign recover_busy             = (r_state != RUN);

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bp_update_sched
//  Brief   : Self-checking bench for bp_update_sched. A queue-level model
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_bp_update_sched;
    import bp_update_sched_pkg::*;

    localparam int UQ_DEPTH       = 4;
    localparam int RECOVER_CYCLES = 2;
    localparam int IW             = c_obq_idx_w;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          rt_en_branch;
    logic          rt_cond_branch;
    logic          rt_direct_branch;
    logic          rt_branch_taken;
    logic          rt_prediction_correct;
    logic [31:0]   rt_pc;
    logic [31:0]   rt_calculated_pc;
    logic [IW-1:0] rt_branch_index;
    logic          rt_ready;
    logic          bp_rt_en_branch;
    logic          bp_rt_cond_branch;
    logic          bp_rt_direct_branch;
    logic          bp_rt_branch_taken;
    logic          bp_rt_prediction_correct;
    logic [31:0]   bp_rt_pc;
    logic [31:0]   bp_rt_calculated_pc;
    logic [IW-1:0] bp_rt_branch_index;
    logic          bp_fetch_stall;
    logic          recover_busy;

    bp_update_sched #(
        .UQ_DEPTH       (UQ_DEPTH),
        .RECOVER_CYCLES (RECOVER_CYCLES)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .rt_en_branch             (rt_en_branch),
        .rt_cond_branch           (rt_cond_branch),
        .rt_direct_branch         (rt_direct_branch),
        .rt_branch_taken          (rt_branch_taken),
        .rt_prediction_correct    (rt_prediction_correct),
        .rt_pc                    (rt_pc),
        .rt_calculated_pc         (rt_calculated_pc),
        .rt_branch_index          (rt_branch_index),
        .rt_ready                 (rt_ready),
        .bp_rt_en_branch          (bp_rt_en_branch),
        .bp_rt_cond_branch        (bp_rt_cond_branch),
        .bp_rt_direct_branch      (bp_rt_direct_branch),
        .bp_rt_branch_taken       (bp_rt_branch_taken),
        .bp_rt_prediction_correct (bp_rt_prediction_correct),
        .bp_rt_pc                 (bp_rt_pc),
        .bp_rt_calculated_pc      (bp_rt_calculated_pc),
        .bp_rt_branch_index       (bp_rt_branch_index),
        .bp_fetch_stall           (bp_fetch_stall),
        .recover_busy             (recover_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Queue-level model: pending updates (mispredict included) leave in
    // order, one per enabled edge; a mispredict blocks new retires until
    // it has issued and the stall window has elapsed.
    // ------------------------------------------------------------------
    typedef struct {
        bit          cond;
        bit          direct;
        bit          taken;
        bit          correct;
        bit [31:0]   pc;
        bit [31:0]   calc;
        bit [IW-1:0] idx;
    } upd_t;

    upd_t mq[$];
    upd_t m_out;
    upd_t m_zero;
    upd_t m_in;
    bit   m_en;
    bit   m_rdy;
    int   m_stall;

    function automatic bit m_has_misp();
        foreach (mq[i]) if (!mq[i].correct) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return enable && (m_stall == 0) && !m_has_misp() && (mq.size() < UQ_DEPTH);
    endfunction

    initial begin
        m_zero = '{cond: 0, direct: 0, taken: 0, correct: 0, pc: 0, calc: 0, idx: 0};
        m_out  = m_zero;
        m_en   = 1'b0;
        m_stall = 0;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_stall = 0;
            m_en    = 1'b0;
            m_out   = m_zero;
        end else begin
            m_rdy = m_ready();
            m_en  = 1'b0;
            m_out = m_zero;
            if (enable) begin
                if (m_stall > 0) m_stall--;
                if (mq.size() > 0) begin
                    m_out = mq.pop_front();
                    m_en  = 1'b1;
                    if (!m_out.correct) m_stall = RECOVER_CYCLES;
                end
                if (m_rdy && rt_en_branch) begin
                    m_in = '{cond: rt_cond_branch, direct: rt_direct_branch,
                             taken: rt_branch_taken, correct: rt_prediction_correct,
                             pc: rt_pc, calc: rt_calculated_pc, idx: rt_branch_index};
                    mq.push_back(m_in);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    bit chk_on = 1'b0;
    always @(negedge clock) begin
        if (chk_on) begin
            check("rt_ready", 32'(rt_ready), 32'(m_ready()));
            check("bp_en", 32'(bp_rt_en_branch), 32'(m_en));
            check("bp_pc", bp_rt_pc, m_out.pc);
            check("bp_calc", bp_rt_calculated_pc, m_out.calc);
            check("bp_idx", 32'(bp_rt_branch_index), 32'(m_out.idx));
            check("bp_flags",
                  32'({bp_rt_cond_branch, bp_rt_direct_branch, bp_rt_branch_taken, bp_rt_prediction_correct}),
                  32'({m_out.cond, m_out.direct, m_out.taken, m_out.correct}));
            check("fetch_stall", 32'(bp_fetch_stall), 32'(m_stall > 0));
            check("recover_busy", 32'(recover_busy), 32'(m_has_misp() || (m_stall > 0)));
        end
    end

    // Log of what actually reached BP, for order checks
    logic [31:0] iss_pc[$];
    bit          iss_corr[$];
    always @(negedge clock) begin
        if (bp_rt_en_branch) begin
            iss_pc.push_back(bp_rt_pc);
            iss_corr.push_back(bp_rt_prediction_correct);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic present(input bit correct, input logic [31:0] pc, input logic [31:0] calc,
                           input logic [IW-1:0] idx);
        rt_en_branch          = 1'b1;
        rt_cond_branch        = pc[2];
        rt_direct_branch      = pc[3];
        rt_branch_taken       = pc[4];
        rt_prediction_correct = correct;
        rt_pc                 = pc;
        rt_calculated_pc      = calc;
        rt_branch_index       = idx;
    endtask

    task automatic idle();
        rt_en_branch          = 1'b0;
        rt_cond_branch        = 1'b0;
        rt_direct_branch      = 1'b0;
        rt_branch_taken       = 1'b0;
        rt_prediction_correct = 1'b0;
        rt_pc                 = '0;
        rt_calculated_pc      = '0;
        rt_branch_index       = '0;
    endtask

    int cnt_a;
    int cnt_b;

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        #2;
        reset  = 1'b0;
        chk_on = 1'b1;
        #1;
        check("post_reset_ready", 32'(rt_ready), 32'd1);
        check("post_reset_busy", 32'(recover_busy), 32'd0);
        tick();

        // Single correct update: visible on BP one edge after acceptance
        present(1'b1, 32'd80, 32'd96, 5'd3);
        tick();
        idle();
        #1;
        check("t2_en_before", 32'(bp_rt_en_branch), 32'd0);
        tick();
        check("t2_en", 32'(bp_rt_en_branch), 32'd1);
        check("t2_pc", bp_rt_pc, 32'd80);
        check("t2_calc", bp_rt_calculated_pc, 32'd96);
        check("t2_idx", 32'(bp_rt_branch_index), 32'd3);
        tick();
        check("t2_en_after", 32'(bp_rt_en_branch), 32'd0);
        check("t2_pc_after", bp_rt_pc, 32'd0);

        // Five back-to-back correct updates, all accepted, issued in order
        iss_pc.delete();
        iss_corr.delete();
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 32'(i), 32'(i + 100), IW'(i));
            #1;
            check("t3_ready", 32'(rt_ready), 32'd1);
            tick();
        end
        idle();
        repeat (4) tick();
        check("t3_count", 32'(iss_pc.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < iss_pc.size()) check("t3_order", iss_pc[i], 32'(i));
        end

        // Two correct then mispredict: ordering and stall window
        iss_pc.delete();
        iss_corr.delete();
        present(1'b1, 32'd4, 32'd20, 5'd1);
        tick();
        present(1'b1, 32'd8, 32'd24, 5'd2);
        tick();
        present(1'b0, 32'd12, 32'd40, 5'd7);
        tick();
        idle();
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            if (bp_fetch_stall) cnt_a++;
            if (!rt_ready) cnt_b++;
            tick();
        end
        check("t4_count", 32'(iss_pc.size()), 32'd3);
        if (iss_pc.size() == 3) begin
            check("t4_first", iss_pc[0], 32'd4);
            check("t4_second", iss_pc[1], 32'd8);
            check("t4_third", iss_pc[2], 32'd12);
            check("t4_misp_correct", 32'(iss_corr[2]), 32'd0);
        end
        check("t4_stall_cycles", 32'(cnt_a), 32'd2);
        check("t4_notready_cycles", 32'(cnt_b), 32'd3);

        // Mispredict into an empty queue
        present(1'b0, 32'd100, 32'd200, 5'd9);
        tick();
        idle();
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            if (recover_busy) cnt_a++;
            if (i == 0) check("t5_en_wait", 32'(bp_rt_en_branch), 32'd0);
            if (i == 1) begin
                check("t5_en", 32'(bp_rt_en_branch), 32'd1);
                check("t5_pc", bp_rt_pc, 32'd100);
                check("t5_correct", 32'(bp_rt_prediction_correct), 32'd0);
            end
            tick();
        end
        check("t5_busy_cycles", 32'(cnt_a), 32'd3);

        // Enable low: nothing issues, nothing accepted, resumes in order
        present(1'b1, 32'd200, 32'd300, 5'd4);
        tick();
        enable = 1'b0;
        present(1'b1, 32'd204, 32'd304, 5'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_ready_off", 32'(rt_ready), 32'd0);
            check("t6_en_off", 32'(bp_rt_en_branch), 32'd0);
            tick();
        end
        enable = 1'b1;
        tick();
        check("t6_resume_en", 32'(bp_rt_en_branch), 32'd1);
        check("t6_resume_pc", bp_rt_pc, 32'd200);
        idle();
        tick();
        check("t6_second_pc", bp_rt_pc, 32'd204);
        tick();

        // Recovery counter holds while disabled
        present(1'b0, 32'd300, 32'd320, 5'd6);
        tick();
        idle();
        tick();
        check("t6_misp_issue", 32'(bp_rt_en_branch), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stall_frozen", 32'(bp_fetch_stall), 32'd1);
        end
        enable = 1'b1;
        tick();
        check("t6_stall_last", 32'(bp_fetch_stall), 32'd1);
        tick();
        check("t6_stall_done", 32'(bp_fetch_stall), 32'd0);
        tick();

        // Reset in the middle of recovery takes effect immediately
        present(1'b0, 32'd400, 32'd440, 5'd8);
        tick();
        idle();
        tick();
        check("t1_in_recover", 32'(bp_fetch_stall), 32'd1);
        reset = 1'b1;
        #1;
        check("t1_en", 32'(bp_rt_en_branch), 32'd0);
        check("t1_pc", bp_rt_pc, 32'd0);
        check("t1_stall", 32'(bp_fetch_stall), 32'd0);
        check("t1_busy", 32'(recover_busy), 32'd0);
        check("t1_ready", 32'(rt_ready), 32'd1);
        tick();
        reset = 1'b0;
        present(1'b1, 32'd500, 32'd520, 5'd2);
        tick();
        idle();
        tick();
        check("t1_after_pc", bp_rt_pc, 32'd500);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
